ioctl_stream_loader: RTL and testbench
======================================

Name: ioctl_stream_loader

Overview:
- Parametrised successor to the fixed bios/cart download path.
- Accepts the HPS ioctl write stream and routes each download by ioctl_index to one of NUM_REGIONS memory regions.
- Packs IN_W-bit ioctl words into OUT_W-bit memory words with byte enables, and buffers them in a small FIFO with valid/ready toward memory.
- Drives ioctl_wait as backpressure and generates the post-download core reset.

Parameters:
- IN_W, 16: ioctl data width; multiple of 8.
- OUT_W, 32: memory word width; OUT_W = IN_W * 2^k, k >= 0.
- ADDR_W, 25: ioctl byte-address width.
- NUM_REGIONS, 2: number of target regions; ioctl_index >= NUM_REGIONS maps to region NUM_REGIONS-1.
- FIFO_DEPTH, 4: output FIFO entries; power of two, >= 2.
- RESET_CYCLES, 255: core-reset hold after the FIFO drains; >= 1.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- ioctl_download, in, 1: download active.
- ioctl_index, in, 8: download target index.
- ioctl_wr, in, 1: one-cycle write strobe.
- ioctl_addr, in, ADDR_W: byte address.
- ioctl_dout, in, IN_W: write data.
- ioctl_wait, out, 1: backpressure to the HPS.
- mem_wr, out, 1: FIFO head valid.
- mem_ready, in, 1: memory accepts the head this cycle.
- mem_region, out, clog2(NUM_REGIONS) (min 1): target region.
- mem_addr, out, ADDR_W-clog2(OUT_W/8): word address.
- mem_data, out, OUT_W: packed data.
- mem_be, out, OUT_W/8: byte enables.
- download_reset, out, 1: hold core in reset.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; FIFO empty; accumulator clear; reset counter cleared.
- Outputs during reset: mem_wr=0, ioctl_wait=0, download_reset=1, busy=0; mem_addr/mem_data/mem_be/mem_region=0.
- Reset asserted mid-operation drops all buffered data; nothing is written to memory after it.
- Lane selection: lane = ioctl_addr[clog2(OUT_W/8)-1 : clog2(IN_W/8)]; RATIO = OUT_W/IN_W.
- Packing: each write places ioctl_dout into lane `lane` of the accumulator and sets that lane's IN_W/8 be bits.
- Accumulator commit: it is pushed to the FIFO when either:
  - the write fills lane RATIO-1, or
  - a write arrives whose word address differs from the accumulator's. The partial word is pushed first; the new data then starts a fresh accumulator. Both happen in the same cycle using a two-slot push, or the implementation stalls through ioctl_wait. Either way no data is lost.
- RATIO=1: every write pushes directly.
- Region: latched on the first ioctl_wr after ioctl_download rises; held for the whole download.
- State machine:
  - IDLE -> LOAD on ioctl_download rising.
  - LOAD -> FLUSH on ioctl_download falling. Any partial accumulator is pushed with only the written lanes enabled.
  - FLUSH -> HOLD once the FIFO is empty and the last mem_wr has been accepted. Counter loads RATIO... no: counter loads RESET_CYCLES.
  - HOLD: counter decrements each cycle; -> IDLE when it reaches 0.
  - HOLD -> LOAD if ioctl_download rises during HOLD; the counter is abandoned.
- download_reset: 1 in LOAD, FLUSH, HOLD and during reset; 0 in IDLE. It is not asserted at power-up beyond reset_n.
- ioctl_wait: registered; 1 when FIFO count >= FIFO_DEPTH-1, which guarantees one in-flight write is always accepted.
- Write with FIFO full: must not occur. Flag it with a sim-only assertion; the word is dropped.
- Memory handshake: mem_wr=1 whenever the FIFO is non-empty. The head is stable until accepted (mem_wr & mem_ready at the clock edge), then pops. Latency from the completing ioctl_wr to mem_wr is 1 cycle when the FIFO is empty.
- Simultaneous push and pop: allowed; count is unchanged.
- ioctl_wr while ioctl_download=0: ignored.

Decomposition:
- Package ioctl_loader_pkg: state enum (IDLE, LOAD, FLUSH, HOLD); FIFO entry struct {region, addr, data, be}; clog2-based width constants.
- One sub-module: sync_fifo, parametrised on width/depth, with count output. The packer and FSM stay in the top.

Test Plan:
- Sequential 16-bit writes at addr 0,2,4,6 (dout 1111,2222,3333,4444), index 0, mem_ready=1 -> two mem_wr pulses:
  - addr 0, data 22221111, be F;
  - addr 1, data 44443333, be F;
  - mem_region=0.
- Odd-length download with a single write at addr 8 (dout ABCD), then download falls -> mem_wr: addr 2, data xxxxABCD, be 3. download_reset stays high for 255 cycles after the FIFO drains, then drops.
- index=5 with NUM_REGIONS=2 -> mem_region=1 for every word.
- mem_ready held 0 during 8 writes -> ioctl_wait=1 once count reaches 3. Release mem_ready -> all 4 words emerge in order with no loss or duplication; ioctl_wait falls.
- Non-sequential writes to addr 0 then addr 0x10 -> partial word 0 (be 3) is pushed, then word 4 accumulates.
- reset_n pulsed low mid-LOAD with 2 FIFO entries -> mem_wr=0 and FIFO empty immediately; download_reset=1; state IDLE after release.

Source files
------------

// File: rtl/ioctl_loader_pkg.sv
// Shared types and width helpers for the ioctl stream loader.
package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_IN_W         = 16;
  localparam int DEF_OUT_W        = 32;
  localparam int DEF_ADDR_W       = 25;
  localparam int DEF_NUM_REGIONS  = 2;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_RESET_CYCLES = 255;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a two-slot push port, so a partial word and a fresh
// full word can both be written in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_push_n,
  input  logic [WIDTH-1:0]           i_din0,
  input  logic [WIDTH-1:0]           i_din1,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic          w_pop;
  logic          w_acc0;
  logic          w_acc1;
  logic [AW-1:0] w_wptr1;
  int            w_space;

  always_comb begin
    w_pop   = i_pop && (r_count != '0);
    w_space = DEPTH - int'(r_count) + (w_pop ? 1 : 0);
    // Anything beyond the free space is dropped rather than corrupting state.
    w_acc0  = (i_push_n != 2'd0) && (w_space >= 1);
    w_acc1  = (i_push_n == 2'd2) && (w_space >= 2);
    w_wptr1 = r_wptr + AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (w_acc0) r_mem[r_wptr]  <= i_din0;
    if (w_acc1) r_mem[w_wptr1] <= i_din1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_acc0) + AW'(w_acc1);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    int'(i_push_n) <= w_space)
    else $error("sync_fifo: write while full, word dropped");
`endif

endmodule

// File: rtl/ioctl_stream_loader.sv
// Packs the HPS ioctl download stream into wide memory words per region,
// buffers them toward memory and holds the core in reset around downloads.
module ioctl_stream_loader
  import ioctl_loader_pkg::*;
#(
  parameter int IN_W         = DEF_IN_W,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int NUM_REGIONS  = DEF_NUM_REGIONS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic                                 clk_sys,
  input  logic                                 reset_n,
  input  logic                                 ioctl_download,
  input  logic [7:0]                           ioctl_index,
  input  logic                                 ioctl_wr,
  input  logic [ADDR_W-1:0]                    ioctl_addr,
  input  logic [IN_W-1:0]                      ioctl_dout,
  output logic                                 ioctl_wait,
  output logic                                 mem_wr,
  input  logic                                 mem_ready,
  output logic [clog2_min1(NUM_REGIONS)-1:0]   mem_region,
  output logic [ADDR_W-$clog2(OUT_W/8)-1:0]    mem_addr,
  output logic [OUT_W-1:0]                     mem_data,
  output logic [OUT_W/8-1:0]                   mem_be,
  output logic                                 download_reset,
  output logic                                 busy
);

  localparam int RATIO   = OUT_W / IN_W;
  localparam int BE_W    = OUT_W / 8;
  localparam int LANE_BE = IN_W / 8;
  localparam int LO      = $clog2(BE_W);
  localparam int IN_LO   = $clog2(LANE_BE);
  localparam int LANE_W  = LO - IN_LO;
  localparam int LANE_WS = (LANE_W > 0) ? LANE_W : 1;
  localparam int REG_W   = clog2_min1(NUM_REGIONS);
  localparam int WADDR_W = ADDR_W - LO;
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
  localparam int RST_W   = $clog2(RESET_CYCLES+1);

  typedef struct packed {
    logic [REG_W-1:0]   region;
    logic [WADDR_W-1:0] addr;
    logic [OUT_W-1:0]   data;
    logic [BE_W-1:0]    be;
  } loader_entry_t;

  state_t             r_state;
  logic [RST_W-1:0]   r_rst_cnt;
  logic               r_dlrst;
  logic               r_busy;
  logic               r_wait;
  logic               r_dl_prev;
  logic [REG_W-1:0]   r_region;
  logic               r_region_ok;
  logic [OUT_W-1:0]   r_acc_data;
  logic [BE_W-1:0]    r_acc_be;
  logic [WADDR_W-1:0] r_acc_addr;

  logic [LANE_WS-1:0] w_lane;
  logic [WADDR_W-1:0] w_waddr;
  logic [REG_W-1:0]   w_idx_region;
  logic [REG_W-1:0]   w_region;
  logic               w_wr, w_rise, w_fall, w_acc_vld, w_diff, w_last, w_pop;
  logic [OUT_W-1:0]   w_new_data;
  logic [BE_W-1:0]    w_new_be;
  logic [1:0]         w_push_n;
  loader_entry_t      w_slot0, w_slot1, w_old, w_fresh, w_head;
  logic [CNT_W-1:0]   w_count;
  int                 w_cnt_next;

  generate
    if (LANE_W > 0) begin : g_lane
      assign w_lane = ioctl_addr[LO-1:IN_LO];
    end else begin : g_no_lane
      assign w_lane = '0;
    end
    if (IN_LO > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^ioctl_addr[IN_LO-1:0];
    end
  endgenerate

  assign w_waddr   = ioctl_addr[ADDR_W-1:LO];
  assign w_wr      = ioctl_wr && ioctl_download;
  assign w_rise    = ioctl_download && !r_dl_prev;
  assign w_fall    = r_dl_prev && !ioctl_download;
  assign w_acc_vld = |r_acc_be;
  assign w_diff    = w_acc_vld && (w_waddr != r_acc_addr);
  assign w_last    = (w_lane == LANE_WS'(RATIO-1));
  assign w_region  = (r_region_ok && !w_rise) ? r_region : w_idx_region;

  always_comb begin
    if (int'(ioctl_index) >= NUM_REGIONS) w_idx_region = REG_W'(NUM_REGIONS-1);
    else                                  w_idx_region = ioctl_index[REG_W-1:0];
  end

  // A write to a new word (or into an empty accumulator) starts from zero.
  always_comb begin
    w_new_data = (w_diff || !w_acc_vld) ? '0 : r_acc_data;
    w_new_be   = (w_diff || !w_acc_vld) ? '0 : r_acc_be;
    for (int l = 0; l < RATIO; l++) begin
      if (w_lane == LANE_WS'(l)) begin
        w_new_data[l*IN_W +: IN_W]     = ioctl_dout;
        w_new_be[l*LANE_BE +: LANE_BE] = '1;
      end
    end
  end

  always_comb begin
    w_old.region   = w_region;
    w_old.addr     = r_acc_addr;
    w_old.data     = r_acc_data;
    w_old.be       = r_acc_be;
    w_fresh.region = w_region;
    w_fresh.addr   = w_waddr;
    w_fresh.data   = w_new_data;
    w_fresh.be     = w_new_be;
    w_push_n = 2'd0;
    w_slot0  = '0;
    w_slot1  = '0;
    if (w_wr) begin
      if (w_diff) begin
        w_slot0 = w_old;
        if (w_last) begin
          w_slot1  = w_fresh;
          w_push_n = 2'd2;
        end else begin
          w_push_n = 2'd1;
        end
      end else if (w_last) begin
        w_slot0  = w_fresh;
        w_push_n = 2'd1;
      end
    end else if (w_fall && w_acc_vld) begin
      w_slot0  = w_old;
      w_push_n = 2'd1;
    end
  end

  assign w_pop = mem_ready && (w_count != '0);

  always_comb begin
    w_cnt_next = int'(w_count) + int'(w_push_n) - (w_pop ? 1 : 0);
  end

  sync_fifo #(
    .WIDTH ($bits(loader_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (clk_sys),
    .i_rst_n  (reset_n),
    .i_push_n (w_push_n),
    .i_din0   (w_slot0),
    .i_din1   (w_slot1),
    .i_pop    (w_pop),
    .o_dout   (w_head),
    .o_count  (w_count)
  );

  always_ff @(posedge clk_sys) begin
    if (w_wr) begin
      r_acc_data <= w_new_data;
      r_acc_addr <= w_waddr;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_be    <= '0;
      r_region    <= '0;
      r_region_ok <= 1'b0;
      r_dl_prev   <= 1'b0;
      r_wait      <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_wait    <= (w_cnt_next >= FIFO_DEPTH-1);
      if (w_wr)        r_acc_be <= w_last ? '0 : w_new_be;
      else if (w_fall) r_acc_be <= '0;
      if (w_wr && (!r_region_ok || w_rise)) begin
        r_region    <= w_idx_region;
        r_region_ok <= 1'b1;
      end else if (w_rise) begin
        r_region_ok <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rst_cnt <= '0;
      r_dlrst   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dlrst <= w_rise;
          r_busy  <= w_rise;
          if (w_rise) r_state <= LOAD;
        end
        LOAD: begin
          if (w_fall) r_state <= FLUSH;
        end
        FLUSH: begin
          if (w_rise) begin
            r_state <= LOAD;
          end else if (w_cnt_next == 0) begin
            r_state   <= HOLD;
            r_rst_cnt <= RST_W'(RESET_CYCLES);
          end
        end
        HOLD: begin
          r_rst_cnt <= r_rst_cnt - RST_W'(1);
          if (w_rise) begin
            r_state <= LOAD;
          end else if (r_rst_cnt <= RST_W'(1)) begin
            r_state <= IDLE;
            r_dlrst <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ioctl_wait     = r_wait;
  assign download_reset = r_dlrst;
  assign busy           = r_busy;
  assign mem_wr         = (w_count != '0);
  assign mem_region     = mem_wr ? w_head.region : '0;
  assign mem_addr       = mem_wr ? w_head.addr   : '0;
  assign mem_data       = mem_wr ? w_head.data   : '0;
  assign mem_be         = mem_wr ? w_head.be     : '0;

endmodule

// File: tb/tb_ioctl_stream_loader.sv
// Directed bench for ioctl_stream_loader at default parameters.
module tb_ioctl_stream_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_wr;
  logic        mem_ready = 1'b1;
  logic [0:0]  mem_region;
  logic [22:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        download_reset;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [0:0]  region;
    logic [22:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } word_t;
  word_t q[$];

  ioctl_stream_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_wr         (mem_wr),
    .mem_ready      (mem_ready),
    .mem_region     (mem_region),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_be         (mem_be),
    .download_reset (download_reset),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if (reset_n && mem_wr && mem_ready) q.push_back({mem_region, mem_addr, mem_data, mem_be});

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [24:0] a, input logic [15:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    step(2);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 700; i++) begin
      if (!download_reset && !busy) break;
      step(1);
    end
    total++; if (download_reset !== 1'b0) begin bad++; $display("FAIL %s_idle download_reset got=%0b exp=0", name, download_reset); end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_wr !== 1'b0)         begin bad++; $display("FAIL rst_mem_wr got=%0b exp=0", mem_wr); end
    total++; if (ioctl_wait !== 1'b0)     begin bad++; $display("FAIL rst_wait got=%0b exp=0", ioctl_wait); end
    total++; if (download_reset !== 1'b1) begin bad++; $display("FAIL rst_dlrst got=%0b exp=1", download_reset); end
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (mem_addr !== 23'd0)      begin bad++; $display("FAIL rst_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_data !== 32'd0)      begin bad++; $display("FAIL rst_data got=%0h exp=0", mem_data); end
    total++; if (mem_be !== 4'd0)         begin bad++; $display("FAIL rst_be got=%0h exp=0", mem_be); end
    total++; if (mem_region !== 1'd0)     begin bad++; $display("FAIL rst_region got=%0h exp=0", mem_region); end
    step(3);
    reset_n = 1'b1;
    step(2);
    total++; if (download_reset !== 1'b0) begin bad++; $display("FAIL post_rst_dlrst got=%0b exp=0", download_reset); end
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL post_rst_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_sequential();
    q.delete();
    mem_ready = 1'b1;
    start_dl(8'd0);
    total++; if (busy !== 1'b1)           begin bad++; $display("FAIL seq_busy got=%0b exp=1", busy); end
    total++; if (download_reset !== 1'b1) begin bad++; $display("FAIL seq_dlrst got=%0b exp=1", download_reset); end
    wr(25'h0, 16'h1111);
    wr(25'h2, 16'h2222);
    total++; if (mem_wr !== 1'b1)           begin bad++; $display("FAIL seq_latency got=%0b exp=1", mem_wr); end
    total++; if (mem_data !== 32'h22221111) begin bad++; $display("FAIL seq_head_data got=%0h exp=22221111", mem_data); end
    wr(25'h4, 16'h3333);
    wr(25'h6, 16'h4444);
    step(3);
    total++; if (q.size() !== 2)               begin bad++; $display("FAIL seq_count got=%0d exp=2", q.size()); end
    total++; if (q[0].addr !== 23'd0)          begin bad++; $display("FAIL seq_w0_addr got=%0h exp=0", q[0].addr); end
    total++; if (q[0].data !== 32'h22221111)   begin bad++; $display("FAIL seq_w0_data got=%0h exp=22221111", q[0].data); end
    total++; if (q[0].be !== 4'hF)             begin bad++; $display("FAIL seq_w0_be got=%0h exp=f", q[0].be); end
    total++; if (q[1].addr !== 23'd1)          begin bad++; $display("FAIL seq_w1_addr got=%0h exp=1", q[1].addr); end
    total++; if (q[1].data !== 32'h44443333)   begin bad++; $display("FAIL seq_w1_data got=%0h exp=44443333", q[1].data); end
    total++; if (q[1].be !== 4'hF)             begin bad++; $display("FAIL seq_w1_be got=%0h exp=f", q[1].be); end
    total++; if (q[0].region !== 1'd0 || q[1].region !== 1'd0) begin bad++; $display("FAIL seq_region got=%0h,%0h exp=0,0", q[0].region, q[1].region); end
    end_dl();
    step(4);
  endtask

  // Starts while the previous download is still in its reset hold.
  task automatic test_region();
    q.delete();
    start_dl(8'd5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reg_busy got=%0b exp=1", busy); end
    wr(25'h0, 16'hAAAA);
    wr(25'h2, 16'hBBBB);
    wr(25'h4, 16'hCCCC);
    step(1);
    end_dl();
    wait_idle("reg");
    total++; if (q.size() !== 2)        begin bad++; $display("FAIL reg_count got=%0d exp=2", q.size()); end
    total++; if (q[0].region !== 1'd1)  begin bad++; $display("FAIL reg_w0_region got=%0h exp=1", q[0].region); end
    total++; if (q[1].region !== 1'd1)  begin bad++; $display("FAIL reg_w1_region got=%0h exp=1", q[1].region); end
    total++; if (q[1].addr !== 23'd1)   begin bad++; $display("FAIL reg_w1_addr got=%0h exp=1", q[1].addr); end
    total++; if (q[1].be !== 4'h3)      begin bad++; $display("FAIL reg_w1_be got=%0h exp=3", q[1].be); end
    total++; if (q[1].data[15:0] !== 16'hCCCC) begin bad++; $display("FAIL reg_w1_data got=%0h exp=cccc", q[1].data[15:0]); end
  endtask

  task automatic test_odd_length();
    int  hold = 0;
    bit  seen = 0;
    q.delete();
    start_dl(8'd0);
    wr(25'h8, 16'hABCD);
    step(1);
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL odd_no_early_push got=%0b exp=0", mem_wr); end
    ioctl_download = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_sys);
      if (mem_wr) seen = 1;
      else if (seen && download_reset) hold++;
      if (seen && !download_reset) break;
    end
    step(1);
    total++; if (hold !== 255)                  begin bad++; $display("FAIL odd_hold_cycles got=%0d exp=255", hold); end
    total++; if (download_reset !== 1'b0)       begin bad++; $display("FAIL odd_dlrst_end got=%0b exp=0", download_reset); end
    total++; if (q.size() !== 1)                begin bad++; $display("FAIL odd_count got=%0d exp=1", q.size()); end
    total++; if (q[0].addr !== 23'd2)           begin bad++; $display("FAIL odd_addr got=%0h exp=2", q[0].addr); end
    total++; if (q[0].data[15:0] !== 16'hABCD)  begin bad++; $display("FAIL odd_data got=%0h exp=abcd", q[0].data[15:0]); end
    total++; if (q[0].be !== 4'h3)              begin bad++; $display("FAIL odd_be got=%0h exp=3", q[0].be); end
  endtask

  task automatic test_nonseq();
    q.delete();
    start_dl(8'd0);
    wr(25'h00, 16'h1234);
    wr(25'h10, 16'h5678);
    total++; if (mem_wr !== 1'b1 || mem_be !== 4'h3 || mem_addr !== 23'd0) begin bad++; $display("FAIL ns_partial_head got=wr%0b be%0h a%0h exp=wr1 be3 a0", mem_wr, mem_be, mem_addr); end
    wr(25'h12, 16'h9ABC);
    wr(25'h20, 16'h1111);
    wr(25'h26, 16'h7777);
    step(4);
    total++; if (q.size() !== 4)                 begin bad++; $display("FAIL ns_count got=%0d exp=4", q.size()); end
    total++; if (q[0].data[15:0] !== 16'h1234)   begin bad++; $display("FAIL ns_w0_data got=%0h exp=1234", q[0].data[15:0]); end
    total++; if (q[1].addr !== 23'd4 || q[1].be !== 4'hF || q[1].data !== 32'h9ABC5678) begin bad++; $display("FAIL ns_w1 got=a%0h be%0h d%0h exp=a4 bef d9abc5678", q[1].addr, q[1].be, q[1].data); end
    total++; if (q[2].addr !== 23'd8 || q[2].be !== 4'h3 || q[2].data[15:0] !== 16'h1111) begin bad++; $display("FAIL ns_w2 got=a%0h be%0h d%0h exp=a8 be3 d1111", q[2].addr, q[2].be, q[2].data[15:0]); end
    total++; if (q[3].addr !== 23'd9 || q[3].be !== 4'hC || q[3].data[31:16] !== 16'h7777) begin bad++; $display("FAIL ns_w3 got=a%0h be%0h d%0h exp=a9 bec d7777", q[3].addr, q[3].be, q[3].data[31:16]); end
    end_dl();
    wait_idle("ns");
  endtask

  task automatic test_backpressure();
    logic [15:0] lo;
    q.delete();
    mem_ready = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 8; i++) begin
      wr(25'(2*i), 16'h1000 + 16'(i));
      if (i == 3) begin
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_cnt2 got=%0b exp=0", ioctl_wait); end
      end
      if (i == 5) begin
        total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL bp_wait_cnt3 got=%0b exp=1", ioctl_wait); end
      end
    end
    step(1);
    total++; if (mem_wr !== 1'b1 || ioctl_wait !== 1'b1) begin bad++; $display("FAIL bp_full got=wr%0b wait%0b exp=wr1 wait1", mem_wr, ioctl_wait); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL bp_held got=%0d exp=0", q.size()); end
    mem_ready = 1'b1;
    step(6);
    total++; if (q.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", q.size()); end
    for (int j = 0; j < 4; j++) begin
      lo = 16'h1000 + 16'(2*j);
      total++; if (q[j].addr !== 23'(j) || q[j].data !== {lo + 16'd1, lo} || q[j].be !== 4'hF) begin bad++; $display("FAIL bp_word%0d got=a%0h d%0h be%0h exp=a%0h d%0h bef", j, q[j].addr, q[j].data, q[j].be, j, {lo + 16'd1, lo}); end
    end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_release got=%0b exp=0", ioctl_wait); end
    end_dl();
    wait_idle("bp");
  endtask

  task automatic test_reset_mid();
    q.delete();
    mem_ready = 1'b0;
    start_dl(8'd0);
    wr(25'h0, 16'h0001);
    wr(25'h2, 16'h0002);
    wr(25'h4, 16'h0003);
    wr(25'h6, 16'h0004);
    total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rm_pre got=%0b exp=1", mem_wr); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_wr !== 1'b0)         begin bad++; $display("FAIL rm_mem_wr got=%0b exp=0", mem_wr); end
    total++; if (download_reset !== 1'b1) begin bad++; $display("FAIL rm_dlrst got=%0b exp=1", download_reset); end
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL rm_busy got=%0b exp=0", busy); end
    total++; if (mem_data !== 32'd0)      begin bad++; $display("FAIL rm_data got=%0h exp=0", mem_data); end
    ioctl_download = 1'b0;
    step(2);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    step(5);
    total++; if (q.size() !== 0)          begin bad++; $display("FAIL rm_no_write got=%0d exp=0", q.size()); end
    total++; if (busy !== 1'b0 || download_reset !== 1'b0) begin bad++; $display("FAIL rm_idle got=busy%0b dlrst%0b exp=0,0", busy, download_reset); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_region();
    test_odd_length();
    test_nonseq();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
